serial_cla_ctrl: RTL and testbench

SERIAL_CLA_CTRL -- requirements
Module: serial_cla_ctrl

---
 rtl/serial_cla_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_cla_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_cla_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice is reused
// LSB nibble first, with a carry register linking consecutive nibbles.
module serial_cla_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CW+1:0] nib_base;
    logic [3:0]    nib_a, nib_b, p, g, slice_s;
    logic [4:0]    c;

    assign nib_base = {cnt_q, 2'b00};
    assign nib_a    = a_q[nib_base +: 4];
    assign nib_b    = b_q[nib_base +: 4];

    // The shared 4-bit carry-lookahead slice.
    assign p    = nib_a ^ nib_b;
    assign g    = nib_a & nib_b;
    assign c[0] = carry_q;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign slice_s = p ^ c[3:0];

    // Only the nibble addressed by the counter is rewritten; the rest hold.
    for (genvar gi = 0; gi < NIB; gi++) begin : g_sum_nib
        assign sum_d[gi*4 +: 4] = (state_q == RUN && cnt_q == CW'(gi))
                                ? slice_s : sum_q[gi*4 +: 4];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    // Subtract is A + ~B + 1, so cin is irrelevant there.
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
                end
            end
            RUN: begin
                carry_d = c[4];
                if (cnt_q == LAST_NIB) begin
                    cout_d  = c[4];
                    ovf_d   = c[3] ^ c[4];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_cla_ctrl.sv
// Directed bench for serial_cla_ctrl (WIDTH=16): hand-computed vectors,
// cycle-exact busy/done timing, start filtering, async reset abort.
module tb_serial_cla_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        cin, op_sub;
    logic        busy, done;
    logic [15:0] sum;
    logic        cout, ovf;

    int vectors     = 0;
    int miscompares = 0;

    serial_cla_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .op_sub(op_sub), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called one step after a rising edge with the DUT idle; returns likewise.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts,
                         input logic [15:0] es, input logic ec, input logic eo);
        a = ta; b = tb_v; cin = tc; op_sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc; op_sub = ~ts;
        check({tag, " busy c0"}, {31'd0, busy}, 32'd1);
        check({tag, " done c0"}, {31'd0, done}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s busy c%0d", tag, k), {31'd0, busy}, 32'd1);
            check($sformatf("%s done c%0d", tag, k), {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        check({tag, " done c4"}, {31'd0, done}, 32'd1);
        check({tag, " busy c4"}, {31'd0, busy}, 32'd1);
        check({tag, " sum"},  {16'd0, sum},  {16'd0, es});
        check({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, " ovf"},  {31'd0, ovf},  {31'd0, eo});
        @(posedge clk); #1;
        check({tag, " done c5"}, {31'd0, done}, 32'd0);
        check({tag, " busy c5"}, {31'd0, busy}, 32'd0);
        check({tag, " sum held"}, {16'd0, sum}, {16'd0, es});
        op_sub = 1'b0; cin = 1'b0;
    endtask

    int done_cnt;

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst sum",  {16'd0, sum},  32'd0);
        check("rst cout", {31'd0, cout}, 32'd0);
        check("rst ovf",  {31'd0, ovf},  32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("addFFFF", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add7FFF", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub5-7",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub8000", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Starts during RUN and DONE must be dropped; operands scrambled in flight.
        a = 16'h0001; b = 16'h0001; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;                       // edge 0
        start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        @(posedge clk); #1;                       // edge 1
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(posedge clk); #1;                       // edge 2
        start = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
        check("ign busy e2", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;                       // edge 3
        @(posedge clk); #1;                       // edge 4
        check("ign done e4", {31'd0, done}, 32'd1);
        check("ign sum", {16'd0, sum}, 32'h0002);
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(posedge clk); #1;                       // edge 5, sampled in DONE
        start = 1'b0;
        check("ign busy e5", {31'd0, busy}, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        check("ign no rerun", done_cnt, 32'd0);
        check("ign sum held", {16'd0, sum}, 32'h0002);

        // Asynchronous reset between edges 2 and 3 aborts the operation.
        a = 16'h1234; b = 16'h1111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst busy", {31'd0, busy}, 32'd0);
        check("arst done", {31'd0, done}, 32'd0);
        check("arst sum",  {16'd0, sum},  32'd0);
        check("arst cout", {31'd0, cout}, 32'd0);
        check("arst ovf",  {31'd0, ovf},  32'd0);
        start = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        check("arst start ignored", done_cnt, 32'd0);
        start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("post rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // start held high: done every 6 cycles, one idle cycle between runs.
        a = 16'h0003; b = 16'h0004; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b done i%0d", i), {31'd0, done}, {31'd0, (i % 6) == 4});
            check($sformatf("b2b busy i%0d", i), {31'd0, busy}, {31'd0, (i % 6) != 5});
            if (done) check($sformatf("b2b sum i%0d", i), {16'd0, sum}, 32'h0007);
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "bench did not finish");
    end
endmodule
